// File: rtl/seq_controller.sv
// Phase sequencer for the SEQ Y86-64 core: owns the PC, steps F->D->E->M->W->PC,
// runs the memory req/ack handshake with a timeout, and latches the halt status.
module seq_controller #(
  parameter int unsigned           PC_W        = 64,
  parameter logic [PC_W-1:0]       RESET_PC    = '0,
  parameter int unsigned           MEM_TIMEOUT = 15,
  parameter int unsigned           CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             hlt,
  input  logic             valid,
  input  logic             error,
  input  logic [PC_W-1:0]  valP,
  input  logic [PC_W-1:0]  valC,
  input  logic             cnd,
  input  logic [PC_W-1:0]  valM,
  input  logic             mem_ack,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             mem_req,
  output logic [2:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int unsigned     TW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(MEM_TIMEOUT - 1);

  state_t          state;
  logic [3:0]      cur_icode;
  logic [TW-1:0]   tmo_cnt;
  logic [4:0]      stage_en;

  assign fetch_en     = stage_en[0];
  assign decode_en    = stage_en[1];
  assign execute_en   = stage_en[2];
  assign memory_en    = stage_en[3];
  assign writeback_en = stage_en[4];

  function automatic logic needs_mem(input logic [3:0] ic);
    return ic inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
  endfunction

  // Stage enables are registered alongside the state: each transition loads the
  // one-hot pattern of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      stage_en    <= '0;
      mem_req     <= 1'b0;
      stat        <= STAT_AOK;
      running     <= 1'b0;
      instr_count <= '0;
      cur_icode   <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state    <= S_FETCH;
          stage_en <= 5'b00001;
          running  <= 1'b1;
        end
        S_FETCH: begin
          state    <= S_DECODE;
          stage_en <= 5'b00010;
        end
        S_DECODE: begin
          cur_icode <= icode;
          if (error || !valid || hlt || icode == 4'd0) begin
            state    <= S_HALTED;
            stage_en <= '0;
            running  <= 1'b0;
            stat     <= error ? STAT_ADR : (!valid ? STAT_INS : STAT_HLT);
          end else begin
            state    <= S_EXECUTE;
            stage_en <= 5'b00100;
          end
        end
        S_EXECUTE: begin
          state    <= S_MEMORY;
          stage_en <= 5'b01000;
          mem_req  <= needs_mem(cur_icode);
          tmo_cnt  <= '0;
        end
        S_MEMORY: begin
          // An ack on the final timeout cycle takes precedence over the fault.
          if (!mem_req || mem_ack) begin
            state    <= S_WRITEBACK;
            stage_en <= 5'b10000;
            mem_req  <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            state    <= S_HALTED;
            stage_en <= '0;
            mem_req  <= 1'b0;
            running  <= 1'b0;
            stat     <= STAT_ADR;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_WRITEBACK: begin
          state    <= S_PCUPD;
          stage_en <= '0;
        end
        S_PCUPD: begin
          case (cur_icode)
            4'd8:    pc <= valC;
            4'd7:    pc <= cnd ? valC : valP;
            4'd9:    pc <= valM;
            default: pc <= valP;
          endcase
          instr_count <= instr_count + CNT_W'(1);
          state       <= S_FETCH;
          stage_en    <= 5'b00001;
        end
        S_HALTED: ;
        default: begin
          state    <= S_IDLE;
          stage_en <= '0;
          running  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: directed instruction table, random instructions checked
// against an instruction-level reference model, and reset-in-MEMORY sequence.
module tb_seq_controller;

  logic        clk = 1'b0;
  logic        rst, start, hlt, valid, error, cnd, mem_ack;
  logic [3:0]  icode;
  logic [63:0] valP, valC, valM, pc;
  logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, mem_req, running;
  logic [2:0]  stat;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  seq_controller #(.PC_W(64), .RESET_PC(64'd0), .MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .hlt(hlt), .valid(valid),
    .error(error), .valP(valP), .valC(valC), .cnd(cnd), .valM(valM), .mem_ack(mem_ack),
    .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .memory_en(memory_en), .writeback_en(writeback_en), .mem_req(mem_req), .stat(stat),
    .running(running), .instr_count(instr_count)
  );

  typedef struct {
    logic [3:0]  icode;
    logic        hlt, valid, error, cnd;
    logic [63:0] valP, valC, valM;
    int unsigned ack;       // MEMORY cycle on which ack is given, 0 = never
    logic [63:0] exp_pc;
    logic [2:0]  exp_stat;
    int unsigned exp_cyc;   // cycles from this FETCH to next FETCH / halt
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] model_pc;
  logic [31:0] model_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 64'd0);
    chk({tag, "_en"}, {59'd0, fetch_en, decode_en, execute_en, memory_en, writeback_en}, 64'd0);
    chk({tag, "_mem_req"}, {63'd0, mem_req}, 64'd0);
    chk({tag, "_stat"}, {61'd0, stat}, 64'd1);
    chk({tag, "_running"}, {63'd0, running}, 64'd0);
    chk({tag, "_count"}, {32'd0, instr_count}, 64'd0);
  endtask

  task automatic reset_start();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");
    @(negedge clk);
    chk("idle_no_start", {63'd0, running}, 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_to_fetch", {63'd0, fetch_en}, 64'd1);
    model_pc  = 64'd0;
    model_cnt = 32'd0;
  endtask

  // Instruction-level reference: outcome of one instruction from the architectural rules.
  task automatic ref_instr(input vec_t v, input logic [63:0] pc_in, output logic [63:0] npc,
                           output logic [2:0] st, output int unsigned cyc, output int unsigned mreq);
    bit is_mem;
    is_mem = v.icode inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
    npc = pc_in; mreq = 0; cyc = 2;
    if (v.error)                          st = 3'd3;
    else if (!v.valid)                    st = 3'd4;
    else if (v.hlt || v.icode == 4'd0)    st = 3'd2;
    else if (is_mem && (v.ack == 0 || v.ack > 15)) begin
      st = 3'd3; mreq = 15; cyc = 3 + 15;
    end else begin
      st   = 3'd1;
      mreq = is_mem ? v.ack : 0;
      cyc  = is_mem ? 5 + v.ack : 6;
      if (v.icode == 4'd8)      npc = v.valC;
      else if (v.icode == 4'd9) npc = v.valM;
      else if (v.icode == 4'd7) npc = v.cnd ? v.valC : v.valP;
      else                      npc = v.valP;
    end
  endtask

  // Called at a negedge where fetch_en is visible; acts as fetch and data memory.
  task automatic run_instr(input vec_t v, input logic [63:0] exp_pc, input logic [2:0] exp_stat,
                           input int unsigned exp_cyc, input int unsigned exp_mreq);
    int unsigned n, mreq;
    logic [63:0] pc0;
    bit          done;
    icode = v.icode; hlt = v.hlt; valid = v.valid; error = v.error; cnd = v.cnd;
    valP = v.valP; valC = v.valC; valM = v.valM; mem_ack = 1'b0;
    n = 0; mreq = 0; pc0 = pc; done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_req) mreq++;
      mem_ack = mem_req && v.ack != 0 && mreq == v.ack;
      chk("onehot_en", {63'd0, ($countones({fetch_en, decode_en, execute_en, memory_en,
          writeback_en}) <= 1)}, 64'd1);
      chk("req_implies_mem_en", {63'd0, (!mem_req || memory_en)}, 64'd1);
      if (fetch_en || !running) done = 1;
      else chk("pc_stable", pc, pc0);
    end
    mem_ack = 1'b0;
    chk("latency", 64'(n), 64'(exp_cyc));
    chk("mem_req_cycles", 64'(mreq), 64'(exp_mreq));
    chk("pc", pc, exp_pc);
    chk("stat", {61'd0, stat}, {61'd0, exp_stat});
    if (exp_stat == 3'd1) model_cnt++;
    model_pc = exp_pc;
    chk("instr_count", {32'd0, instr_count}, {32'd0, model_cnt});
  endtask

  // HALTED is terminal: outputs hold and start is ignored.
  task automatic check_halted_hold(input logic [2:0] exp_stat);
    logic [63:0] pc0;
    pc0 = pc;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("halt_running", {63'd0, running}, 64'd0);
    chk("halt_fetch_en", {63'd0, fetch_en}, 64'd0);
    chk("halt_pc", pc, pc0);
    chk("halt_stat", {61'd0, stat}, {61'd0, exp_stat});
  endtask

  vec_t tbl[16];

  initial begin
    vec_t          v;
    logic [63:0]   npc;
    logic [2:0]    st;
    int unsigned   cyc, mreq, r, k;

    tbl[0]  = '{4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 64'h1,   64'h0,   64'h0,  0,  64'h1,   3'd1, 6};
    tbl[1]  = '{4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 64'hA,   64'h0,   64'h0,  0,  64'h1,   3'd2, 2};
    tbl[2]  = '{4'd7,  1'b0, 1'b1, 1'b0, 1'b1, 64'h9,   64'h40,  64'h0,  0,  64'h40,  3'd1, 6};
    tbl[3]  = '{4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 64'h9,   64'h40,  64'h0,  0,  64'h9,   3'd1, 6};
    tbl[4]  = '{4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 64'h12,  64'h100, 64'h0,  1,  64'h100, 3'd1, 6};
    tbl[5]  = '{4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 64'h101, 64'h0,   64'h2A, 2,  64'h2A,  3'd1, 7};
    tbl[6]  = '{4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 64'h34,  64'h8,   64'h0,  3,  64'h34,  3'd1, 8};
    tbl[7]  = '{4'd4,  1'b0, 1'b1, 1'b0, 1'b0, 64'h3E,  64'h8,   64'h0,  15, 64'h3E,  3'd1, 20};
    tbl[8]  = '{4'd6,  1'b0, 1'b1, 1'b0, 1'b0, 64'h40,  64'h0,   64'h0,  0,  64'h40,  3'd1, 6};
    tbl[9]  = '{4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 64'h4A,  64'h8,   64'h0,  0,  64'h40,  3'd3, 18};
    tbl[10] = '{4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 64'hA,   64'h5,   64'h0,  0,  64'hA,   3'd1, 6};
    tbl[11] = '{4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 64'hB,   64'h0,   64'h0,  0,  64'hA,   3'd4, 2};
    tbl[12] = '{4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 64'h14,  64'h5,   64'h0,  0,  64'h14,  3'd1, 6};
    tbl[13] = '{4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1E,  64'h0,   64'h0,  0,  64'h14,  3'd3, 2};
    tbl[14] = '{4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 64'h2,   64'h0,   64'h0,  16, 64'h0,   3'd3, 18};
    tbl[15] = '{4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 64'h2,   64'h0,   64'h0,  0,  64'h0,   3'd2, 2};

    rst = 1'b1; start = 1'b0; icode = '0; hlt = 1'b0; valid = 1'b1; error = 1'b0;
    cnd = 1'b0; valP = '0; valC = '0; valM = '0; mem_ack = 1'b0;
    model_pc = '0; model_cnt = '0;
    repeat (2) @(negedge clk);

    reset_start();
    for (int i = 0; i < 16; i++) begin
      run_instr(tbl[i], tbl[i].exp_pc, tbl[i].exp_stat, tbl[i].exp_cyc,
                (tbl[i].exp_stat == 3'd1) ? ((tbl[i].exp_cyc == 6 &&
                 !(tbl[i].icode inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11})) ? 0
                 : tbl[i].exp_cyc - 5) : ((tbl[i].exp_cyc == 18) ? 15 : 0));
      if (tbl[i].exp_stat != 3'd1) begin
        check_halted_hold(tbl[i].exp_stat);
        reset_start();
      end
    end

    for (int i = 0; i < 60; i++) begin
      v.icode = 4'($urandom_range(0, 11));
      v.hlt   = ($urandom % 16) == 0;
      v.valid = ($urandom % 12) != 0;
      v.error = ($urandom % 25) == 0;
      v.cnd   = 1'($urandom);
      v.valP  = {$urandom, $urandom};
      v.valC  = {$urandom, $urandom};
      v.valM  = {$urandom, $urandom};
      r = $urandom % 10;
      v.ack   = (r == 0) ? 0 : (r == 1) ? 15 : (r == 2) ? 16 : $urandom_range(1, 5);
      ref_instr(v, model_pc, npc, st, cyc, mreq);
      run_instr(v, npc, st, cyc, mreq);
      if (st != 3'd1) begin
        check_halted_hold(st);
        reset_start();
      end
    end

    // Reset while the memory handshake is pending.
    reset_start();
    v = '{4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h77, 64'h0, 64'h0, 0, 64'h77, 3'd1, 6};
    run_instr(v, 64'h77, 3'd1, 6, 0);
    icode = 4'd5; valP = 64'h99;
    k = 0;
    while (!mem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("mem_req_seen", {63'd0, mem_req}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rst_in_mem");
    @(negedge clk);
    chk("stay_idle", {63'd0, running | fetch_en}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
